// File: rtl/mult_issue_pkg.sv
// Shared types for the multiplier issue controller: FSM states, widths, tag layout.
// No logic; types and constants only.
// Imported by mult_issue_ctrl and mult_res_fifo.
package mult_issue_pkg;

  localparam int DATA_W  = 32;
  localparam int PROD_W  = 64;
  localparam int DEF_LAT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LO = 2'd1,
    ISSUE_HI = 2'd2
  } state_t;

  // Travels alongside each issued slot through the adder pipeline.
  typedef struct packed {
    logic vld;
    logic hi;
    logic lo_only;
  } tag_t;

  localparam tag_t TAG_NONE = '{vld: 1'b0, hi: 1'b0, lo_only: 1'b0};

endpackage

// File: rtl/mult_res_fifo.sv
// Result buffer: DEPTH-entry FIFO of assembled products, head is a register read.
// Latency: push visible on head/count the cycle after the push edge.
// Backpressure: none internally; upstream credits keep pushes away from a full FIFO.
module mult_res_fifo
  import mult_issue_pkg::*;
#(
  parameter int W     = PROD_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          full;

  // A pop on an empty FIFO is ignored so push+pop on empty is a plain push.
  assign pop_ok = pop && (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rd_ptr];

  // Storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Credits must make an overflowing push impossible.
  assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop_ok));

endmodule

// File: rtl/mult_issue_ctrl.sv
// Feeds operand pairs to the LAT-stage 32x32 multiplier as LO/HI slots, rebuilds 64-bit products.
// Latency: accept at edge E0 -> product pushed at edge E0+LAT+2 (E0+LAT+1 for lo-only ops).
// Backpressure: credit pool of FIFO_DEPTH; in_ready drops when no credit. Option: MULT_ISSUE_LO_ONLY_EN.
module mult_issue_ctrl
  import mult_issue_pkg::*;
#(
  parameter int LAT        = DEF_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
`ifdef MULT_ISSUE_LO_ONLY_EN
  input  logic              in_lo_only,
`endif
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_s,
  input  logic [DATA_W-1:0] mul_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic              lo_only_q;
  logic              lo_only_in;
  logic              accept;
  logic              pop;
  logic              push;
  logic [PROD_W-1:0] push_dat;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] lo_reg;
  tag_t              stage0;
  tag_t              out_tag;
  tag_t              tag_pipe [LAT];

`ifdef MULT_ISSUE_LO_ONLY_EN
  assign lo_only_in = in_lo_only;
`else
  assign lo_only_in = 1'b0;
`endif

  // A lo-only op frees the issue slot right after its LO cycle.
  assign in_ready = reset && (credits != '0) &&
                    ((state == IDLE) || (state == ISSUE_HI) ||
                     ((state == ISSUE_LO) && lo_only_q));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Issue FSM; mul_a/mul_b double as the operand registers and read 0 when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      lo_only_q <= 1'b0;
    end else begin
      case (state)
        ISSUE_LO: begin
          if (!lo_only_q) begin
            state <= ISSUE_HI;
          end else if (accept) begin
            state     <= ISSUE_LO;
            mul_a     <= in_a;
            mul_b     <= in_b;
            lo_only_q <= lo_only_in;
          end else begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            lo_only_q <= 1'b0;
          end
        end
        IDLE, ISSUE_HI: begin
          if (accept) begin
            state     <= ISSUE_LO;
            mul_a     <= in_a;
            mul_b     <= in_b;
            lo_only_q <= lo_only_in;
          end else begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            lo_only_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag entering the adder pipeline alongside this cycle's operands.
  always_comb begin
    stage0 = TAG_NONE;
    case (state)
      ISSUE_LO: stage0 = '{vld: 1'b1, hi: 1'b0, lo_only: lo_only_q};
      ISSUE_HI: stage0 = '{vld: 1'b1, hi: 1'b1, lo_only: 1'b0};
      default:  stage0 = TAG_NONE;
    endcase
  end

  // Tag delay line matching the multiplier latency; reset drops stale slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= stage0;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_tag = tag_pipe[LAT-1];
  assign mul_s   = out_tag.vld ? ~out_tag.hi : 1'b1;

  // Hold the low word until its HI partner arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_reg <= '0;
    end else if (out_tag.vld && !out_tag.hi && !out_tag.lo_only) begin
      lo_reg <= mul_c;
    end
  end

  assign push     = out_tag.vld && (out_tag.hi || out_tag.lo_only);
  assign push_dat = out_tag.lo_only ? {{DATA_W{1'b0}}, mul_c} : {mul_c, lo_reg};

  // Credit pool: one taken per accepted op, returned when its product leaves the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  mult_res_fifo #(
    .W     (PROD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (out_p),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a behavioural LAT-cycle multiplier.
// Drives at posedge+1, checks at negedge against a timing/arithmetic reference model.
// Covers directed plan items plus a randomized phase with random out_ready and valid gaps.
module tb_mult_issue_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        lo;
  } stim_t;

  typedef struct {
    logic [63:0] prod;
    int          arrive;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_lo_only;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_s;
  logic [31:0] mul_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  stim_t stimq[$];
  exp_t  expq[$];
  int    hiq[$];
  int    credits_m = DEPTH;
  int    last_acc  = -100;
  logic  last_lo   = 1'b0;
  logic  drv_acc   = 1'b0;
  logic  rand_mode = 1'b0;
  logic [63:0] last_pop = '0;
  logic [63:0] mpipe [LAT];

  mult_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MULT_ISSUE_LO_ONLY_EN
    .in_lo_only (in_lo_only),
`endif
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_s      (mul_s),
    .mul_c      (mul_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: full product delayed LAT cycles, s picks the half.
  initial for (int i = 0; i < LAT; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_c = mul_s ? mpipe[LAT-1][31:0] : mpipe[LAT-1][63:32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic lo);
    stim_t s;
    s.a = a;
    s.b = b;
`ifdef MULT_ISSUE_LO_ONLY_EN
    s.lo = lo;
`else
    s.lo = 1'b0;
    if (lo) s.lo = 1'b0;
`endif
    stimq.push_back(s);
  endtask

  task automatic wait_drain(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (stimq.size() == 0 && expq.size() == 0) done = 1;
    end
    chk("drain_within_bound", 64'(done), 64'd1);
  endtask

  // Driver: presents the stimulus queue head; optional random gaps and consumer stalls.
  initial begin
    in_valid = 0; in_a = '0; in_b = '0; in_lo_only = 0;
    forever begin
      @(posedge clk); #1;
      if (drv_acc && stimq.size() > 0) void'(stimq.pop_front());
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      if (stimq.size() > 0 && !(rand_mode && $urandom_range(0, 3) == 0)) begin
        in_valid   = 1;
        in_a       = stimq[0].a;
        in_b       = stimq[0].b;
        in_lo_only = stimq[0].lo;
      end else begin
        in_valid   = 0;
        in_lo_only = 0;
      end
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    logic exp_v, exp_s, exp_r;
    if (!reset) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_p", out_p, 64'd0);
      chk("rst_mul_s", 64'(mul_s), 64'd1);
      chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      expq.delete();
      hiq.delete();
      credits_m = DEPTH;
      last_acc  = -100;
      last_lo   = 0;
      drv_acc   = 0;
    end else begin
      exp_v = (expq.size() > 0) && (expq[0].arrive <= cyc);
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      while (hiq.size() > 0 && hiq[0] < cyc) void'(hiq.pop_front());
      exp_s = !(hiq.size() > 0 && hiq[0] == cyc);
      chk("mul_s", 64'(mul_s), 64'(exp_s));
      exp_r = (credits_m > 0) && !(last_acc == cyc && !last_lo);
      chk("in_ready", 64'(in_ready), 64'(exp_r));
      if (out_valid && out_ready && expq.size() > 0) begin
        chk("out_p", out_p, expq[0].prod);
        last_pop = out_p;
        void'(expq.pop_front());
        credits_m++;
      end
      drv_acc = in_valid && in_ready;
      if (drv_acc) begin
        exp_t e;
        logic [63:0] full;
        full = {32'b0, in_a} * {32'b0, in_b};
        e.prod   = in_lo_only ? {32'b0, full[31:0]} : full;
        e.arrive = cyc + LAT + (in_lo_only ? 2 : 3);
        expq.push_back(e);
        credits_m--;
        last_acc = cyc + 1;
        last_lo  = in_lo_only;
        if (!in_lo_only) hiq.push_back(cyc + 2 + LAT);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // Single op: 0xFFFFFFFF * 2.
    @(negedge clk);
    add_op(32'hFFFF_FFFF, 32'h2, 0);
    wait_drain(60);
    chk("single_product", last_pop, 64'h0000_0001_FFFF_FFFE);

    // Back-to-back ops.
    @(negedge clk);
    for (int i = 0; i < 8; i++) add_op(32'(i + 1), 32'h1_0000, 0);
    wait_drain(120);
    chk("b2b_last_product", last_pop, 64'h8_0000);

    // Consumer stalled: only DEPTH ops may enter.
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 6; i++) add_op(32'(100 + i), 32'(7 + i), 0);
    repeat (40) @(negedge clk);
    chk("stall_pending_ops", 64'(stimq.size()), 64'd2);
    out_ready = 1;
    wait_drain(150);

    // Accept and pop on the same edge with one credit left.
    @(negedge clk);
    out_ready = 0;
    for (int i = 0; i < 3; i++) add_op(32'(20 + i), 32'h3, 0);
    repeat (30) @(negedge clk);
    add_op(32'hABCD, 32'h11, 0);
    @(posedge clk); #1 out_ready = 1;
    wait_drain(100);

    // Reset while an op is in flight: its product must never appear.
    @(negedge clk);
    add_op(32'h1234_5678, 32'h9, 0);
    while (stimq.size() > 0) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (20) @(negedge clk);
    @(negedge clk);
    add_op(32'h3, 32'h5, 0);
    wait_drain(60);
    chk("post_reset_product", last_pop, 64'hF);

`ifdef MULT_ISSUE_LO_ONLY_EN
    // Lo-only ops: low word only, accepted every cycle.
    @(negedge clk);
    add_op(32'h8000_0000, 32'h4, 1);
    wait_drain(60);
    chk("lo_only_product", last_pop, 64'h0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) add_op($urandom, $urandom, 1);
    wait_drain(100);
`endif

    // Randomized traffic with stalls and gaps.
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 10 == 0) a = 32'hFFFF_FFFF;
      if (i % 10 == 1) b = 32'h0;
      add_op(a, b, 1'($urandom_range(0, 1)));
    end
    rand_mode = 1;
    wait_drain(4000);
    rand_mode = 0;
    out_ready = 1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Upstream feeder for the 32x32 multiplier: the multiplier has 32-bit A/B operands, LAT-stage partial-product adder, and a combinational half-select s (s=1 low word, s=0 high word) applied to its final sum.
- Accepts operand pairs on a valid/ready port, issues each pair twice (LO slot, then HI slot) and steers s so the matching half appears on C. Assembles both halves into a 64-bit product and buffers it in a result FIFO.
- The adder pipeline has no stall, so back-pressure uses credits.

Parameters:
- LAT, 4, multiplier latency in clocks (operands presented in cycle k give sum in cycle k+LAT)
- FIFO_DEPTH, 4, result FIFO entries; also the credit pool size (power of 2, >=2)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  operand pair valid
- in_ready  output  1  pair accepted on edge where in_valid & in_ready
- in_a  input  32  multiplicand
- in_b  input  32  multiplier
- mul_a  output  32  to multiplier A
- mul_b  output  32  to multiplier B
- mul_s  output  1  to multiplier s
- mul_c  input  32  from multiplier C
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer pops on out_valid & out_ready
- out_p  output  64  product {hi,lo}, FIFO head

Behaviour:
- Reset (reset=0, async): state=IDLE; op regs=0; mul_a=mul_b=0; mul_s=1; tag pipe cleared; lo_reg=0; FIFO empty; out_valid=0; out_p=0; credits=FIFO_DEPTH; in_ready=0 while reset asserted.
- FSM states and transitions:
  - IDLE -> ISSUE_LO on accept.
  - ISSUE_LO -> ISSUE_HI unconditionally.
  - ISSUE_HI -> ISSUE_LO on accept, else IDLE.
- in_ready = (state==IDLE | state==ISSUE_HI) & credits!=0. Peak throughput is one product per 2 cycles.
- Accept loads op regs from in_a/in_b.
- mul_a/mul_b = op regs in ISSUE_LO/ISSUE_HI, 0 in IDLE.
- Tag pipe: LAT-deep shift of {vld,hi}. The stage-0 value is {1,0} in ISSUE_LO, {1,1} in ISSUE_HI, {0,0} in IDLE.
- Output-stage tag is aligned with sum on mul_c. mul_s = ~out_tag.hi when out_tag.vld, else 1.
- Out tag {1,0}: lo_reg <= mul_c.
- Out tag {1,1}: push {mul_c, lo_reg} into the FIFO.
- Latency: accept at edge E0 -> LO issued cycle after E0 -> push at edge E0+LAT+2 -> out_valid high from that edge. out_p is the FIFO head, registered.
- Credits: decrement on accept, increment on pop; simultaneous accept+pop leaves credits unchanged.
- Credits guarantee no push to a full FIFO. A push when full is an assertion failure.
- FIFO: pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when full or empty is legal. An empty FIFO with a same-edge push raises out_valid next cycle.
- Arithmetic is unsigned; product = in_a*in_b mod 2^64 exactly.
- Reset mid-operation flushes tags, so stale multiplier results are ignored. Lost in-flight products are not recovered.

Optional Feature:
- Macro MULT_ISSUE_LO_ONLY_EN adds input port in_lo_only (1 bit, sampled on accept).
- With the macro, when the flag is set: ISSUE_LO goes to IDLE/ISSUE_LO and skips ISSUE_HI. The tag is {1,0} with a lo_only bit, and that result pushes {32'b0, mul_c} directly. in_ready is also high in ISSUE_LO for lo_only ops.
- Without the macro: no port, and every op issues both slots.

Decomposition:
- Package mult_issue_pkg: state encoding (IDLE/ISSUE_LO/ISSUE_HI), DATA_W=32, PROD_W=64, default LAT, tag field layout.
- Sub-module mult_res_fifo (PROD_W wide, FIFO_DEPTH deep, count output) holds the result buffer.
- The bench uses a behavioural multiplier model with LAT-cycle delay and combinational s-select.

Test Plan:
- Single op a=0xFFFFFFFF, b=0x2, out_ready=1 -> out_p=0x00000001_FFFFFFFE, out_valid rises LAT+2 edges after accept; mul_s 1 then 0 on consecutive cycles.
- Back-to-back 8 ops a=i+1, b=0x10000 (i=0..7), out_ready=1 -> in_ready alternating pattern (1 accept / 2 cycles), products (i+1)<<16 in order.
- out_ready=0, 6 ops offered -> exactly FIFO_DEPTH(4) accepted, in_ready stays 0. Then out_ready=1 -> 4 pops in order, credits return, remaining 2 accepted.
- Accept and pop on the same edge with credits=1 -> credits stays 1, in_ready stays high.
- Reset pulse 2 cycles after accepting a=0x12345678, b=0x9 -> no output ever appears; out_valid=0, credits=4; the next op 0x3*0x5 yields 0xF.
- With MULT_ISSUE_LO_ONLY_EN: a=0x80000000, b=0x4, in_lo_only=1 -> out_p=0x0000000000000000. Consecutive lo_only ops are accepted every cycle.
